// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes 11-bit frames and
// turns E0/F0 prefixed scan codes into one-cycle make/break event pulses.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyCode,
    output logic       newKey,
    output logic       keyRelease,
    output logic       extended,
    output logic       frameError
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_level;
    logic                  fall_edge;
    logic                  data_bit;

    state_t                state;
    logic [2:0]            bitcnt;
    logic [7:0]            shift_reg;
    logic                  parity_bit;
    logic                  ext_flag;
    logic                  brk_flag;
    logic [TW-1:0]         tcount;

    // The filtered clock only moves once every sample in the window agrees,
    // so short glitches on the cable never look like a bit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt_sr    <= '1;
            filt_level <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_sr   <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
            if (&filt_sr)
                filt_level <= 1'b1;
            else if (~|filt_sr)
                filt_level <= 1'b0;
        end
    end

    assign fall_edge = filt_level && (filt_sr == '0);
    assign data_bit  = data_sync[1];

    // Byte decode happens on the stop-bit edge itself so the registered
    // pulses appear exactly one clk after that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            tcount     <= '0;
            keyCode    <= '0;
            newKey     <= 1'b0;
            keyRelease <= 1'b0;
            extended   <= 1'b0;
            frameError <= 1'b0;
        end else begin
            newKey     <= 1'b0;
            keyRelease <= 1'b0;
            frameError <= 1'b0;
            if (fall_edge) begin
                tcount <= '0;
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_bit, shift_reg[7:1]};
                        bitcnt    <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= data_bit;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_bit && (^{shift_reg, parity_bit})) begin
                            case (shift_reg)
                                8'hE0: ext_flag <= 1'b1;
                                8'hF0: brk_flag <= 1'b1;
                                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFF: begin
                                    ext_flag <= 1'b0;
                                    brk_flag <= 1'b0;
                                end
                                default: begin
                                    keyCode    <= shift_reg;
                                    extended   <= ext_flag;
                                    newKey     <= !brk_flag;
                                    keyRelease <= brk_flag;
                                    ext_flag   <= 1'b0;
                                    brk_flag   <= 1'b0;
                                end
                            endcase
                        end else begin
                            frameError <= 1'b1;
                            ext_flag   <= 1'b0;
                            brk_flag   <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // A stalled keyboard must not leave us stuck mid-frame.
                if (tcount == TW'(TIMEOUT - 1)) begin
                    state    <= IDLE;
                    tcount   <= '0;
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end else begin
                    tcount <= tcount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames push expected
// events, a monitor pops and compares whenever a pulse appears.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN = 8;
    localparam int TO         = 1000;
    localparam int HALF       = 20;

    localparam logic [2:0] K_MAKE  = 3'b001;
    localparam logic [2:0] K_BREAK = 3'b010;
    localparam logic [2:0] K_ERR   = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keyCode;
    logic       newKey;
    logic       keyRelease;
    logic       extended;
    logic       frameError;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] code;
        logic       ext;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .keyCode(keyCode),
        .newKey(newKey),
        .keyRelease(keyRelease),
        .extended(extended),
        .frameError(frameError)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expectEvent(input logic [2:0] kind, input logic [7:0] code, input logic ext);
        exp_t e;
        e.kind = kind;
        e.code = code;
        e.ext  = ext;
        sb.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic p, input logic stop);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++)
            sendBit(b[i]);
        sendBit(p);
        sendBit(stop);
        ps2_data = 1'b1;
        waitCycles(3 * HALF);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_keyCode"}, 32'(keyCode), 32'h0);
        checkOutput({tag, "_newKey"}, 32'(newKey), 32'h0);
        checkOutput({tag, "_keyRelease"}, 32'(keyRelease), 32'h0);
        checkOutput({tag, "_extended"}, 32'(extended), 32'h0);
        checkOutput({tag, "_frameError"}, 32'(frameError), 32'h0);
    endtask

    // Monitor: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && (newKey || keyRelease || frameError)) begin
            checkOutput("exclusive_pulses", 32'(newKey & keyRelease), 32'h0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {29'b0, frameError, keyRelease, newKey}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("pulse_kind", {29'b0, frameError, keyRelease, newKey}, {29'b0, mon_e.kind});
                checkOutput("keyCode", 32'(keyCode), 32'(mon_e.code));
                checkOutput("extended", 32'(extended), 32'(mon_e.ext));
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        waitCycles(20);

        // plain make, then a typematic repeat
        expectEvent(K_MAKE, 8'h74, 1'b0);
        applyStimulus(8'h74, 1'b1, 1'b1);
        expectEvent(K_MAKE, 8'h74, 1'b0);
        applyStimulus(8'h74, 1'b1, 1'b1);

        // extended break
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b1, 1'b1);
        expectEvent(K_BREAK, 8'h6B, 1'b1);
        applyStimulus(8'h6B, 1'b0, 1'b1);

        // extended make, then prefixes in reverse order
        applyStimulus(8'hE0, 1'b0, 1'b1);
        expectEvent(K_MAKE, 8'h75, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b1, 1'b1);
        applyStimulus(8'hE0, 1'b0, 1'b1);
        expectEvent(K_BREAK, 8'h72, 1'b1);
        applyStimulus(8'h72, 1'b1, 1'b1);

        // parity error keeps previous code, then recovery
        expectEvent(K_ERR, 8'h72, 1'b1);
        applyStimulus(8'h72, 1'b0, 1'b1);
        expectEvent(K_MAKE, 8'h72, 1'b0);
        applyStimulus(8'h72, 1'b1, 1'b1);

        // stop-bit error
        expectEvent(K_ERR, 8'h72, 1'b0);
        applyStimulus(8'h74, 1'b1, 1'b0);

        // short glitch with data low must not start a frame
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (FILTER_LEN - 2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        waitCycles(HALF);
        ps2_data = 1'b1;
        waitCycles(HALF);

        // timeout mid-frame also drops a pending E0
        applyStimulus(8'hE0, 1'b0, 1'b1);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++)
            sendBit(1'b1);
        ps2_data = 1'b1;
        waitCycles(TO + 10);
        expectEvent(K_MAKE, 8'h75, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b1);

        // suppressed BAT code, which also clears a pending E0
        applyStimulus(8'hAA, 1'b1, 1'b1);
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'hAA, 1'b1, 1'b1);
        expectEvent(K_MAKE, 8'h74, 1'b0);
        applyStimulus(8'h74, 1'b1, 1'b1);

        // reset mid-frame after F0
        applyStimulus(8'hF0, 1'b1, 1'b1);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        ps2_data = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        waitCycles(50);
        expectEvent(K_MAKE, 8'h74, 1'b0);
        applyStimulus(8'h74, 1'b1, 1'b1);

        for (int i = 0; i < 200 && sb.size() != 0; i++)
            @(posedge clk);
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
